// File: rtl/accum20_pkg.sv
// Shared types and constants for the time-shared 20-bit accumulator block.
// ACCUM20_SAT_EN selects saturating write-back in accum20_scheduler.
package accum20_pkg;
   localparam int ACC_W = 20;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   localparam logic [ACC_W-1:0] SAT_POS = 20'h7FFFF;
   localparam logic [ACC_W-1:0] SAT_NEG = 20'h80000;
endpackage

// File: rtl/accum20_scheduler_if.sv
// Requester-side handshake bundle: req/sub/delta in, ack/busy back.
// Parameterised by channel count.
interface accum20_scheduler_if #(
   parameter int N_CH = 4
) ();
   import accum20_pkg::*;

   logic [N_CH-1:0]       req;
   logic [N_CH-1:0]       sub;
   logic [N_CH*ACC_W-1:0] delta;
   logic [N_CH-1:0]       ack;
   logic                  busy;

   modport master (
      output req, sub, delta,
      input  ack, busy
   );

   modport slave (
      input  req, sub, delta,
      output ack, busy
   );
endinterface

// File: rtl/full_adder20.sv
// 20-bit ripple-carry adder, bit-serial carry chain.
// Purely combinational; the caller registers operands.
module full_adder20
   import accum20_pkg::*;
(
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic             c_in,
   output logic [ACC_W-1:0] sum,
   output logic             c_out
);
   logic [ACC_W:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = c_in;
      for (int i = 0; i < ACC_W; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign c_out = c[ACC_W];
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or after ptr, wrapping.
// Produces a one-hot grant and its index.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx
);
   int c;

   always_comb begin
      gnt = '0;
      idx = '0;
      c   = 0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr) + k) % N;
         if (gnt == '0 && req[W'(c)]) begin
            gnt[W'(c)] = 1'b1;
            idx        = W'(c);
         end
      end
   end
endmodule

// File: rtl/accum20_scheduler.sv
// Shares one ripple adder among N_CH signed accumulators (IDLE->EXEC->WB).
// ACCUM20_SAT_EN: saturate instead of wrap on signed overflow.
module accum20_scheduler
   import accum20_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   accum20_scheduler_if.slave bus,
   input  logic [N_CH-1:0]   clr,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [ACC_W-1:0]  rd_data,
   output logic [N_CH-1:0]   ovf,
   input  logic              ovf_clr
);
   state_t           state;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] g;
   logic [SEL_W-1:0] gnt_idx;
   logic [N_CH-1:0]  gnt;
   logic [ACC_W-1:0] acc [N_CH];
   logic [ACC_W-1:0] opa, opb, sum, sum_r, result, din;
   logic             cin, ovf_r, carry_unused;

   rr_arbiter #(.N(N_CH), .W(SEL_W)) u_arb (
      .req (bus.req),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   full_adder20 u_add (
      .a     (opa),
      .b     (opb),
      .c_in  (cin),
      .sum   (sum),
      .c_out (carry_unused)
   );

   assign din = bus.delta[int'(gnt_idx)*ACC_W +: ACC_W];

`ifdef ACCUM20_SAT_EN
   assign result = !ovf_r ? sum_r :
                   (opa[ACC_W-1] ? SAT_NEG : SAT_POS);
`else
   assign result = sum_r;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         g        <= '0;
         opa      <= '0;
         opb      <= '0;
         cin      <= 1'b0;
         sum_r    <= '0;
         ovf_r    <= 1'b0;
         bus.ack  <= '0;
         bus.busy <= 1'b0;
         ovf      <= '0;
         rd_data  <= '0;
         for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      end else begin
         rd_data <= (int'(rd_sel) < N_CH) ? acc[rd_sel] : '0;
         if (ovf_clr) ovf <= '0;
         unique case (state)
            IDLE: begin
               if (|gnt) begin
                  g        <= gnt_idx;
                  opa      <= acc[gnt_idx];
                  opb      <= bus.sub[gnt_idx] ? ~din : din;
                  cin      <= bus.sub[gnt_idx];
                  bus.busy <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               sum_r      <= sum;
               ovf_r      <= (opa[ACC_W-1] == opb[ACC_W-1]) &&
                             (sum[ACC_W-1] != opa[ACC_W-1]);
               bus.ack[g] <= 1'b1;
               state      <= WB;
            end
            WB: begin
               bus.ack  <= '0;
               bus.busy <= 1'b0;
               rr_ptr   <= (g == SEL_W'(N_CH-1)) ? '0 : g + 1'b1;
               state    <= IDLE;
               // a coincident clear discards the write and its overflow
               if (!clr[g]) begin
                  acc[g] <= result;
                  if (ovf_r) ovf[g] <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         for (int i = 0; i < N_CH; i++)
            if (clr[i]) acc[i] <= '0;
      end
   end
endmodule

// File: tb/tb_accum20_scheduler.sv
// Directed bench for accum20_scheduler: op table plus arbitration,
// clear-vs-writeback and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_accum20_scheduler;
   import accum20_pkg::*;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;

`ifdef ACCUM20_SAT_EN
   localparam logic [19:0] POS_OVF = 20'h7FFFF;
   localparam logic [19:0] NEG_OVF = 20'h80000;
`else
   localparam logic [19:0] POS_OVF = 20'h80000;
   localparam logic [19:0] NEG_OVF = 20'h7FFFA;
`endif

   typedef struct {
      int          ch;
      logic        s;
      logic [19:0] d;
      logic [19:0] exp_acc;
      logic        exp_ovf;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_CH-1:0]  clr;
   logic [SEL_W-1:0] rd_sel;
   logic [19:0]      rd_data;
   logic [N_CH-1:0]  ovf;
   logic             ovf_clr;

   int n_cmp = 0;
   int n_bad = 0;
   int ord_q[$];
   int at_q[$];
   logic [19:0] v;
   vec_t tbl[11];

   accum20_scheduler_if #(.N_CH(N_CH)) bif ();

   accum20_scheduler #(.N_CH(N_CH), .SEL_W(SEL_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bif),
      .clr     (clr),
      .rd_sel  (rd_sel),
      .rd_data (rd_data),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_acc(input int ch, output logic [19:0] val);
      rd_sel = SEL_W'(ch);
      tick();
      val = rd_data;
   endtask

   task automatic do_op(input int ch, input logic s, input logic [19:0] d);
      int n;
      bit got;
      bif.req[ch]             = 1'b1;
      bif.sub[ch]             = s;
      bif.delta[ch*20 +: 20]  = d;
      n   = 0;
      got = 0;
      while (!got && n < 8) begin
         tick();
         n++;
         if (n == 1) check($sformatf("busy_exec_ch%0d", ch), 32'(bif.busy), 1);
         if (bif.ack[ch]) got = 1;
      end
      check($sformatf("ack_lat_ch%0d", ch), got ? n : 99, 2);
      bif.req[ch] = 1'b0;
      tick();
   endtask

   task automatic collect(input int want);
      int cyc;
      ord_q.delete();
      at_q.delete();
      cyc = 0;
      while (ord_q.size() < want && cyc < 40) begin
         tick();
         cyc++;
         for (int i = 0; i < N_CH; i++) begin
            if (bif.ack[i]) begin
               ord_q.push_back(i);
               at_q.push_back(cyc);
               bif.req[i] = 1'b0;
            end
         end
      end
      check("collect_count", ord_q.size(), want);
      tick();
   endtask

   initial begin
      tbl[0]  = '{0, 1'b0, 20'd5,     20'd5,     1'b0};
      tbl[1]  = '{2, 1'b0, 20'd3,     20'd3,     1'b0};
      tbl[2]  = '{2, 1'b1, 20'd10,    20'hFFFF9, 1'b0};
      tbl[3]  = '{1, 1'b0, 20'd4,     20'd4,     1'b0};
      tbl[4]  = '{3, 1'b1, 20'd1,     20'hFFFFF, 1'b0};
      tbl[5]  = '{3, 1'b0, 20'd2,     20'd1,     1'b0};
      tbl[6]  = '{0, 1'b1, 20'd5,     20'd0,     1'b0};
      tbl[7]  = '{0, 1'b0, 20'h7FFFF, 20'h7FFFF, 1'b0};
      tbl[8]  = '{0, 1'b0, 20'd1,     POS_OVF,   1'b1};
      tbl[9]  = '{2, 1'b1, 20'h7FFFF, NEG_OVF,   1'b1};
      tbl[10] = '{3, 1'b0, 20'd0,     20'd1,     1'b0};

      reset     = 1'b1;
      clr       = '0;
      ovf_clr   = 1'b0;
      rd_sel    = '0;
      bif.req   = '0;
      bif.sub   = '0;
      bif.delta = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_ack", 32'(bif.ack), 0);
      check("rst_busy", 32'(bif.busy), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_rd_data", 32'(rd_data), 0);

      for (int k = 0; k < 11; k++) begin
         do_op(tbl[k].ch, tbl[k].s, tbl[k].d);
         read_acc(tbl[k].ch, v);
         check($sformatf("tbl%0d_acc", k), 32'(v), 32'(tbl[k].exp_acc));
         check($sformatf("tbl%0d_ovf", k), 32'(ovf[tbl[k].ch]), 32'(tbl[k].exp_ovf));
      end

      check("ovf_vec", 32'(ovf), 32'h5);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(ovf), 0);
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      read_acc(0, v);
      check("clr0_idle", 32'(v), 0);

      // all four at once, rr_ptr is 0 after the ch3 op
      bif.sub   = '0;
      bif.delta = {4{20'd1}};
      bif.req   = '1;
      collect(4);
      for (int k = 0; k < ord_q.size(); k++) begin
         check($sformatf("rr4_order%0d", k), ord_q[k], k);
         check($sformatf("rr4_at%0d", k), at_q[k], 2 + 3*k);
      end
      read_acc(1, v);
      check("rr4_acc1", 32'(v), 5);

      bif.req[1] = 1'b1;
      bif.req[3] = 1'b1;
      collect(2);
      if (ord_q.size() == 2) begin
         check("rr2_first", ord_q[0], 1);
         check("rr2_second", ord_q[1], 3);
      end
      read_acc(3, v);
      check("rr2_acc3", 32'(v), 3);

      // clear coinciding with write-back of ch1
      clr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      do_op(1, 1'b0, 20'd4);
      read_acc(1, v);
      check("pre_clr_acc1", 32'(v), 4);
      bif.sub[1]         = 1'b0;
      bif.delta[20 +: 20] = 20'd9;
      bif.req[1]         = 1'b1;
      tick();
      check("clrwb_busy", 32'(bif.busy), 1);
      tick();
      check("clrwb_ack", 32'(bif.ack), 32'h2);
      check("clrwb_rd_prewrite", 32'(rd_data), 4);
      clr[1] = 1'b1;
      tick();
      clr[1]     = 1'b0;
      bif.req[1] = 1'b0;
      check("clrwb_ack_done", 32'(bif.ack), 0);
      read_acc(1, v);
      check("clrwb_acc1", 32'(v), 0);
      check("clrwb_ovf1", 32'(ovf[1]), 0);

      // reset during EXEC of ch3
      bif.sub[3]          = 1'b0;
      bif.delta[60 +: 20] = 20'd5;
      bif.req[3]          = 1'b1;
      tick();
      check("abort_busy", 32'(bif.busy), 1);
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      bif.req[3] = 1'b0;
      check("abort_ack", 32'(bif.ack), 0);
      check("abort_busy_low", 32'(bif.busy), 0);
      tick();
      check("abort_ack2", 32'(bif.ack), 0);
      read_acc(3, v);
      check("abort_acc3", 32'(v), 0);

      bif.delta = {4{20'd2}};
      bif.req[0] = 1'b1;
      bif.req[3] = 1'b1;
      collect(2);
      if (ord_q.size() == 2) begin
         check("ptr_reset_first", ord_q[0], 0);
         check("ptr_reset_second", ord_q[1], 3);
      end
      read_acc(3, v);
      check("post_abort_acc3", 32'(v), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/accum20_scheduler.md
# accum20_scheduler

Time-shares one 20-bit ripple adder among N_CH requesters that each own a signed 20-bit accumulator, such as encoder tick counts or odometry sums. Requesters post add or subtract operations through a req/ack handshake. A round-robin scheduler grants one request at a time and sequences operand load, add, and write-back. Accumulator values, with sticky overflow flags, are read back through a registered read port.

## Interface
- N_CH, 4: number of requesters/accumulators, 2..8
- SEL_W, $clog2(N_CH): read-select width
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high; one clock, all state sampled on rising clk
- req  in  N_CH  request per channel; held high until ack
- sub  in  N_CH  1 = subtract delta, 0 = add; held stable with req
- delta  in  N_CH*20  signed operand per channel, slice [20*i+19:20*i]; held stable with req
- clr  in  N_CH  synchronous clear of accumulator i
- ack  out  N_CH  one-cycle completion pulse for the granted channel
- busy  out  1  high when not IDLE
- rd_sel  in  SEL_W  read channel select
- rd_data  out  20  registered value of accumulator rd_sel
- ovf  out  N_CH  sticky signed-overflow flag per channel
- ovf_clr  in  1  clears all ovf bits

## Operation
- FSM: IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - If any req is set, grant the first set channel at or after rr_ptr (wrapping) and latch the operands into registers: opA = acc[g], opB = sub ? ~delta[g] : delta[g], cin = sub. Go to EXEC.
  - If no req is set, stay in IDLE.
- EXEC: the adder evaluates the registered operands; sum and signed overflow are latched. Overflow = (opA[19] == opB[19]) && (sum[19] != opA[19]).
- WB:
  - acc[g] <= result and ack[g] = 1.
  - If overflow, set ovf[g].
  - rr_ptr <= g+1, wrapping to 0 after N_CH-1.
  - Return to IDLE.
- Arithmetic is two's complement mod 2^20 unless saturation is compiled in (see Configuration).
- clr[i] zeroes acc[i] at the next edge. If clr[g] coincides with the WB of channel g, clr wins: the write is discarded, ack is still issued, and ovf is not set.
- ovf_clr and an overflow set in the same cycle: the set wins.
- req dropped before ack (protocol violation): the operation completes on the latched operands and ack still pulses.
- Reset values: state IDLE, rr_ptr 0, all acc 0, ack 0, busy 0, ovf 0, rd_data 0.
- Reset asserted mid-operation aborts it: no ack and no accumulator write.

## Timing
- A request is sampled in IDLE at cycle t. EXEC runs at t+1. ack is high during t+2 (WB). The new acc value is visible at t+3.
- Throughput is one operation per 3 cycles. The next grant is evaluated in the IDLE cycle after WB.
- A requester deasserts req, or presents the next operation, on the edge that ends the ack cycle. The IDLE sample at t+3 therefore sees the updated req.
- rd_data = acc[rd_sel] as of the previous edge, with 1-cycle latency. During WB it shows the pre-write value.
- busy is high in EXEC and WB.

## Configuration
- ACCUM20_SAT_EN defined: on overflow, WB writes 20'h7FFFF for positive overflow (opA[19] = 0) or 20'h80000 for negative overflow. ovf is still set.
- ACCUM20_SAT_EN undefined: the wrapped sum is written. No saturation logic is present.

## Structure
- Package accum20_pkg holds:
  - ACC_W = 20
  - state enum {IDLE, EXEC, WB}
  - SAT_POS and SAT_NEG constants
- Arithmetic is one full_adder20 instance, (a, b, c_in, sum, c_out), fed only from registered operands.
- The natural sub-module is rr_arbiter: a parameterised round-robin grant from req and rr_ptr, producing a one-hot grant and an index.

## Test plan
- Reset, then ch0 add delta=5 at t → ack[0] at t+2; rd_sel=0 reads 5 at t+4; busy high at t+1..t+2.
- All four req high at once with rr_ptr=0 → acks in order 0,1,2,3, 3 cycles apart. Then ch1 and ch3 re-request → ch3 (next after ptr) before ch1? No: ptr=0 after ch3, so ch1 then ch3.
- ch2 acc=3, sub with delta=10 → acc = 20'hFFFF9 (-7), ovf[2]=0.
- ch0 acc=20'h7FFFF, add 1 → without macro acc=20'h80000; with ACCUM20_SAT_EN acc=20'h7FFFF. ovf[0]=1 in both; ovf_clr clears it.
- clr[1] asserted during WB of ch1 (add 9 to 4) → acc[1]=0, ack[1] pulses, ovf[1] unchanged.
- reset asserted during EXEC of ch3 → no ack[3], acc[3]=0, state IDLE, rr_ptr=0.
